// File: rtl/rom_sample_reader_if.sv
// Sample stream link from the ROM reader to the downstream DSP stage.
// Valid/ready handshake; m_last marks the final sample of a pass.
interface rom_sample_reader_if #(
  parameter int WIDTH = 8
);
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/rom_sample_reader.sv
// ROM sample reader: walks a window [base, base+length) of a combinational
// ROM and streams the samples over valid/ready at one sample per cycle.
// Optional looping restarts at base with no bubble between passes.
module rom_sample_reader #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  loop,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]      rom_dout,
  rom_sample_reader_if.master   m,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   IDX_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;
  logic [ADDR_WIDTH-1:0] base_reg, base_next;
  logic [ADDR_WIDTH-1:0] len_reg, len_next;
  logic                  loop_reg, loop_next;
  // index counts one past the largest pass (2**ADDR_WIDTH samples)
  logic [ADDR_WIDTH:0]   idx_reg, idx_next;
  logic                  all_loaded_reg, all_loaded_next;
  logic                  valid_reg, valid_next;
  logic [WIDTH-1:0]      data_reg, data_next;
  logic                  last_reg, last_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;

  logic [ADDR_WIDTH:0]   len_full;
  logic                  is_last;
  logic                  load;

  // length 0 encodes a full-address-space pass
  assign len_full = {(len_reg == '0), len_reg};
  assign is_last  = (idx_reg == (len_full - IDX_ONE));
  // output register can take a new sample when empty or being drained
  assign load     = (!valid_reg || m.m_ready) && !all_loaded_reg;

  assign rom_addr  = ptr_reg;
  assign m.m_valid = valid_reg;
  assign m.m_data  = data_reg;
  assign m.m_last  = last_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

  // State and datapath registers; async reset to the idle values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      base_reg       <= '0;
      len_reg        <= '0;
      loop_reg       <= 1'b0;
      idx_reg        <= '0;
      all_loaded_reg <= 1'b0;
      valid_reg      <= 1'b0;
      data_reg       <= '0;
      last_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      base_reg       <= base_next;
      len_reg        <= len_next;
      loop_reg       <= loop_next;
      idx_reg        <= idx_next;
      all_loaded_reg <= all_loaded_next;
      valid_reg      <= valid_next;
      data_reg       <= data_next;
      last_reg       <= last_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  // Next-state, load/drain and pass-end decisions
  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    base_next       = base_reg;
    len_next        = len_reg;
    loop_next       = loop_reg;
    idx_next        = idx_reg;
    all_loaded_next = all_loaded_reg;
    valid_next      = valid_reg;
    data_next       = data_reg;
    last_next       = last_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        // abort in the same cycle suppresses the start
        if (start && !abort) begin
          state_next      = STREAM;
          base_next       = base_addr;
          len_next        = length;
          loop_next       = loop;
          ptr_next        = base_addr;
          idx_next        = '0;
          all_loaded_next = 1'b0;
          valid_next      = 1'b0;
          last_next       = 1'b0;
          busy_next       = 1'b1;
        end
      end
      STREAM: begin
        if (abort) begin
          state_next = IDLE;
          valid_next = 1'b0;
          last_next  = 1'b0;
          busy_next  = 1'b0;
        end else if (load) begin
          data_next  = rom_dout;
          valid_next = 1'b1;
          last_next  = is_last;
          if (is_last && loop_reg) begin
            ptr_next = base_reg;
            idx_next = '0;
          end else begin
            ptr_next = ptr_reg + PTR_ONE;
            idx_next = idx_reg + IDX_ONE;
          end
          if (is_last && !loop_reg) begin
            all_loaded_next = 1'b1;
          end
        end else if (valid_reg && m.m_ready) begin
          // nothing left to load, so this handshake retires the final sample
          state_next = DONE;
          valid_next = 1'b0;
          last_next  = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        last_next  = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule
